// File: rtl/m_tx_scheduler_if.sv
// Requester and transmitter bus of the frame scheduler.
//   Requester side: i_req, i_len, i_byte, i_byte_valid -> scheduler;
//                   o_byte_ready, o_grant, o_done <- scheduler.
//   Transmitter side: i_data_left -> scheduler; o_data, o_data_we <- scheduler.
// slave = scheduler view, master = requester/transmitter (testbench) view.
interface m_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ*8-1:0] i_len;
  logic [NUM_REQ*8-1:0] i_byte;
  logic [NUM_REQ-1:0]   i_byte_valid;
  logic [NUM_REQ-1:0]   o_byte_ready;
  logic [NUM_REQ-1:0]   o_grant;
  logic [NUM_REQ-1:0]   o_done;
  logic [7:0]           i_data_left;
  logic [7:0]           o_data;
  logic                 o_data_we;

  modport slave (
    input  i_req, i_len, i_byte, i_byte_valid, i_data_left,
    output o_byte_ready, o_grant, o_done, o_data, o_data_we
  );

  modport master (
    output i_req, i_len, i_byte, i_byte_valid, i_data_left,
    input  o_byte_ready, o_grant, o_done, o_data, o_data_we
  );
endinterface

// File: rtl/m_tx_scheduler.sv
// Round-robin frame scheduler in front of the Manchester byte transmitter.
// Grants one requester at a time, waits until the transmitter buffer can hold
// header + payload, then writes the length header followed by the payload.
// A requester that stalls for TIMEOUT cycles has its frame padded with
// PAD_BYTE so the transmitter always sees len+1 bytes.
// Ports:
//   i_clk_2x  system clock shared with the transmitter
//   i_rst     synchronous active-high reset
//   bus       requester/transmitter bus (m_tx_scheduler_if.slave)
//   o_err     1-cycle pulse on zero-length frame or timeout abort
//   o_busy    high whenever the scheduler is not idle
module m_tx_scheduler #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic            i_clk_2x,
  input  logic            i_rst,
  m_tx_scheduler_if.slave bus,
  output logic            o_err,
  output logic            o_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_HDR, S_PAYLOAD, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           rem_q, rem_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 abort_q, abort_d;
  logic [7:0]           data_q, data_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic [7:0]           len_a  [NUM_REQ];
  logic [7:0]           byte_a [NUM_REQ];
  logic                 sel_found_c;
  logic [IDX_W-1:0]     sel_idx_c;
  logic [IDX_W-1:0]     cand_c;
  logic                 pad_c;
  logic                 rdy_c;

  // Unpack the per-requester byte lanes
  for (genvar k = 0; k < int'(NUM_REQ); k++) begin : g_lane
    assign len_a[k]  = bus.i_len[8*k +: 8];
    assign byte_a[k] = bus.i_byte[8*k +: 8];
  end

  // Round-robin pick: first requester after rr_q, wrapping
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    cand_c      = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand_c = IDX_W'((int'(rr_q) + k) % int'(NUM_REQ));
      if (!sel_found_c && bus.i_req[cand_c]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = cand_c;
      end
    end
  end

  // Padding starts on the cycle the stall timer reaches TIMEOUT and then sticks
  assign pad_c = (state_q == S_PAYLOAD) && (rem_q != 8'd0) &&
                 (abort_q || ((TIMEOUT != 0) && (tmr_q == TMR_W'(TIMEOUT))));
  assign rdy_c = (state_q == S_PAYLOAD) && (rem_q != 8'd0) && !pad_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    len_d   = len_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    abort_d = abort_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = '0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_found_c) begin
          g_d     = sel_idx_c;
          grant_d = NUM_REQ'(1) << sel_idx_c;
          len_d   = len_a[sel_idx_c];
          state_d = S_CHECK;
          // Zero-length pulses are registered here so they line up with CHECK
          if (len_a[sel_idx_c] == 8'd0) begin
            done_d = NUM_REQ'(1) << sel_idx_c;
            err_d  = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (len_q == 8'd0) begin
          grant_d = '0;
          rr_d    = g_q;
          state_d = S_IDLE;
        end else if ({1'b0, bus.i_data_left} >= (9'(len_q) + 9'd1)) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        data_d  = len_q;
        we_d    = 1'b1;
        rem_d   = len_q;
        tmr_d   = '0;
        abort_d = 1'b0;
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // rem_q == 0 is the cycle the last registered write is on the bus
        if (rem_q == 8'd0) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (pad_c) begin
          data_d  = PAD_BYTE;
          we_d    = 1'b1;
          rem_d   = rem_q - 8'd1;
          abort_d = 1'b1;
          err_d   = !abort_q;
        end else if (bus.i_byte_valid[g_q]) begin
          data_d  = byte_a[g_q];
          we_d    = 1'b1;
          rem_d   = rem_q - 8'd1;
          tmr_d   = '0;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        grant_d = '0;
        rr_d    = g_q;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk_2x) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      tmr_q   <= '0;
      abort_q <= 1'b0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      abort_q <= abort_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_byte_ready = rdy_c ? grant_q : '0;
  assign bus.o_grant      = grant_q;
  assign bus.o_done       = done_q;
  assign bus.o_data       = data_q;
  assign bus.o_data_we    = we_q;
  assign o_err            = err_q;
  assign o_busy           = busy_q;

endmodule
